// File: rtl/lct_blk_fifo_if.sv
// ---------------------------------------------------------------------------
// lct_blk_fifo_if
// Bus between the LCT block-address queue and its two neighbours.
//
// The block-address allocator supplies the push side:
//   LCT, PUSH, ENBL50, DISBL50, PREBLKEND, LOADPBLK, DIN, DSCAFULL
// The L1A read controller owns the pop side:
//   POP, DOUT, DLSCAFULL, LCT_PHASE
// The queue reports its occupancy on:
//   NLCT, FULL_1, EMPT_B, FULL
//
// master : the allocator/read-controller side (drives requests, sees status)
// slave  : the queue itself
// ---------------------------------------------------------------------------
interface lct_blk_fifo_if;
    logic        LCT;
    logic        PUSH;
    logic        POP;
    logic        ENBL50;
    logic        DISBL50;
    logic        PREBLKEND;
    logic [3:0]  LOADPBLK;
    logic [11:0] DIN;
    logic [2:0]  DSCAFULL;

    logic [3:0]  DOUT;
    logic [7:0]  NLCT;
    logic        LCT_PHASE;
    logic        FULL_1;
    logic        EMPT_B;
    logic        FULL;
    logic        DLSCAFULL;

    modport master (
        output LCT, PUSH, POP, ENBL50, DISBL50, PREBLKEND, LOADPBLK, DIN, DSCAFULL,
        input  DOUT, NLCT, LCT_PHASE, FULL_1, EMPT_B, FULL, DLSCAFULL
    );

    modport slave (
        input  LCT, PUSH, POP, ENBL50, DISBL50, PREBLKEND, LOADPBLK, DIN, DSCAFULL,
        output DOUT, NLCT, LCT_PHASE, FULL_1, EMPT_B, FULL, DLSCAFULL
    );
endinterface

// File: rtl/lct_blk_fifo.sv
// ---------------------------------------------------------------------------
// lct_blk_fifo
// 16-deep queue of LCT block-address entries for the SCA controller. Each
// entry holds three 4-bit SCA block addresses (pre, LCT, post), their
// SCA-full flags and the 50 ns phase captured at LCT time. The read side
// drains the head entry one block address per POP.
//
// Ports:
//   CLK  - system clock, all state updates on the rising edge
//   RST  - asynchronous, active-high reset
//   bus  - lct_blk_fifo_if.slave:
//          LCT       in   phase capture strobe
//          PUSH      in   write one entry {phase_hold, DSCAFULL, DIN}
//          POP       in   consume the current head block address
//          ENBL50    in   sets the phase flag
//          DISBL50   in   clears the phase flag (wins over ENBL50)
//          PREBLKEND in   unused
//          LOADPBLK  in   bit 3: read the pre block first
//          DIN       in   [11:8] pre, [7:4] LCT, [3:0] post block address
//          DSCAFULL  in   [2] pre, [1] LCT, [0] post SCA-full flags
//          DOUT      out  head block address at the current sub-index
//          NLCT      out  stored entry count, zero-extended
//          LCT_PHASE out  phase bit of the head entry
//          FULL_1    out  count >= 15
//          EMPT_B    out  count != 0
//          FULL      out  count == 16
//          DLSCAFULL out  SCA-full flag of the head block address
//
// Parameter TMR=1 keeps three copies of every state register (control and
// storage) and majority-votes them on every read; behaviour is unchanged.
// ---------------------------------------------------------------------------
module lct_blk_fifo #(
    parameter int TMR = 0
) (
    input  logic          CLK,
    input  logic          RST,
    lct_blk_fifo_if.slave bus
);

    localparam int NC = (TMR != 0) ? 3 : 1;

    typedef struct packed {
        logic       ph;
        logic [2:0] sf;
        logic [11:0] din;
    } entry_t;

    typedef struct packed {
        logic [3:0] wptr;
        logic [3:0] rptr;
        logic [4:0] count;
        logic [1:0] sidx;
        logic       phase;
        logic       hold;
        logic       empt_b;
        logic       full_1;
        logic       full;
    } ctrl_t;

    ctrl_t  ctrl_q [NC];
    ctrl_t  ctrl_v;
    ctrl_t  ctrl_d;
    entry_t mem_q  [NC][16];
    entry_t head_v;

    logic       has_entry;
    logic       retire;
    logic       advance;
    logic       push_ok;
    logic [1:0] start_idx;

    // Inputs that have no function in this block.
    logic unused_inputs;
    assign unused_inputs = ^{bus.PREBLKEND, bus.LOADPBLK[2:0]};

    // Majority voting of the redundant copies (pass-through when single).
    generate
        if (NC == 3) begin : g_tmr
            assign ctrl_v = ctrl_t'((ctrl_q[0] & ctrl_q[1]) |
                                    (ctrl_q[0] & ctrl_q[2]) |
                                    (ctrl_q[1] & ctrl_q[2]));
            assign head_v = entry_t'((mem_q[0][ctrl_v.rptr] & mem_q[1][ctrl_v.rptr]) |
                                     (mem_q[0][ctrl_v.rptr] & mem_q[2][ctrl_v.rptr]) |
                                     (mem_q[1][ctrl_v.rptr] & mem_q[2][ctrl_v.rptr]));
        end else begin : g_single
            assign ctrl_v = ctrl_q[0];
            assign head_v = mem_q[0][ctrl_v.rptr];
        end
    endgenerate

    assign has_entry = (ctrl_v.count != 5'd0);
    assign retire    = bus.POP && has_entry && (ctrl_v.sidx == 2'd2);
    assign advance   = bus.POP && has_entry && (ctrl_v.sidx != 2'd2);
    // A retiring POP frees a slot in the same cycle, so a full queue can
    // still accept a push alongside it.
    assign push_ok   = bus.PUSH && (!ctrl_v.full || retire);
    assign start_idx = bus.LOADPBLK[3] ? 2'd0 : 2'd1;

    always_comb begin
        ctrl_d = ctrl_v;

        if (push_ok) begin
            ctrl_d.wptr = ctrl_v.wptr + 4'd1;
        end
        if (retire) begin
            ctrl_d.rptr = ctrl_v.rptr + 4'd1;
        end
        ctrl_d.count = ctrl_v.count + {4'd0, push_ok} - {4'd0, retire};

        // The start sub-index is sampled whenever a new entry becomes head:
        // on retirement, or when a push lands in an empty queue.
        if (advance) begin
            ctrl_d.sidx = ctrl_v.sidx + 2'd1;
        end else if (retire || (push_ok && !has_entry)) begin
            ctrl_d.sidx = start_idx;
        end

        if (bus.DISBL50) begin
            ctrl_d.phase = 1'b0;
        end else if (bus.ENBL50) begin
            ctrl_d.phase = 1'b1;
        end

        if (bus.LCT) begin
            ctrl_d.hold = ctrl_v.phase;
        end

        // Status flags are registered from the next count so they change
        // on the same edge as the count itself.
        ctrl_d.empt_b = (ctrl_d.count != 5'd0);
        ctrl_d.full_1 = (ctrl_d.count >= 5'd15);
        ctrl_d.full   = (ctrl_d.count == 5'd16);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < NC; c++) begin
                ctrl_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                ctrl_q[c] <= ctrl_d;
            end
        end
    end

    // Entry storage carries no reset; emptiness is tracked by the count.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            for (int c = 0; c < NC; c++) begin
                mem_q[c][ctrl_v.wptr] <= '{ph: ctrl_v.hold, sf: bus.DSCAFULL, din: bus.DIN};
            end
        end
    end

    always_comb begin
        bus.DOUT      = 4'd0;
        bus.DLSCAFULL = 1'b0;
        bus.LCT_PHASE = 1'b0;
        if (has_entry) begin
            bus.LCT_PHASE = head_v.ph;
            case (ctrl_v.sidx)
                2'd0: begin
                    bus.DOUT      = head_v.din[11:8];
                    bus.DLSCAFULL = head_v.sf[2];
                end
                2'd1: begin
                    bus.DOUT      = head_v.din[7:4];
                    bus.DLSCAFULL = head_v.sf[1];
                end
                2'd2: begin
                    bus.DOUT      = head_v.din[3:0];
                    bus.DLSCAFULL = head_v.sf[0];
                end
                default: begin
                    bus.DOUT      = 4'd0;
                    bus.DLSCAFULL = 1'b0;
                end
            endcase
        end
    end

    assign bus.NLCT   = {3'b000, ctrl_v.count};
    assign bus.EMPT_B = ctrl_v.empt_b;
    assign bus.FULL_1 = ctrl_v.full_1;
    assign bus.FULL   = ctrl_v.full;

endmodule

// File: tb/tb_lct_blk_fifo.sv
// ---------------------------------------------------------------------------
// tb_lct_blk_fifo
// Directed scenarios followed by randomized traffic, compared every cycle
// against a queue-based reference model of the LCT block-address queue.
// ---------------------------------------------------------------------------
module tb_lct_blk_fifo;

    logic clk;
    logic rst;

    lct_blk_fifo_if bus ();

    lct_blk_fifo #(.TMR(0)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ph;
        logic [2:0]  sf;
        logic [11:0] din;
    } ref_entry_t;

    ref_entry_t mq[$];
    int         m_pos;      // which of the three block addresses is next
    logic       m_flag;
    logic       m_hold;

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pos  = 0;
        m_flag = 1'b0;
        m_hold = 1'b0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge(input logic push, input logic pop, input logic lct,
                              input logic en, input logic dis, input logic [3:0] load,
                              input logic [11:0] din, input logic [2:0] sf);
        int  n;
        int  first;
        bit  ret;
        bit  adv;
        bit  take;
        ref_entry_t e;
        n     = mq.size();
        first = load[3] ? 0 : 1;
        ret   = pop && (n > 0) && (m_pos == 2);
        adv   = pop && (n > 0) && (m_pos < 2);
        take  = push && ((n < 16) || ret);
        if (ret) void'(mq.pop_front());
        if (take) begin
            e.ph  = m_hold;
            e.sf  = sf;
            e.din = din;
            mq.push_back(e);
        end
        if (adv) m_pos = m_pos + 1;
        else if (ret || (take && n == 0)) m_pos = first;
        if (lct) m_hold = m_flag;
        if (dis) m_flag = 1'b0;
        else if (en) m_flag = 1'b1;
    endtask

    task automatic check_all(input string tag);
        logic [3:0] e_dout;
        logic       e_dl;
        logic       e_ph;
        int         n;
        n      = mq.size();
        e_dout = 4'd0;
        e_dl   = 1'b0;
        e_ph   = 1'b0;
        if (n > 0) begin
            e_ph = mq[0].ph;
            case (m_pos)
                0: begin e_dout = mq[0].din[11:8]; e_dl = mq[0].sf[2]; end
                1: begin e_dout = mq[0].din[7:4];  e_dl = mq[0].sf[1]; end
                default: begin e_dout = mq[0].din[3:0]; e_dl = mq[0].sf[0]; end
            endcase
        end
        chk({tag, ".dout"},  32'(bus.DOUT),      32'(e_dout));
        chk({tag, ".dlsf"},  32'(bus.DLSCAFULL), 32'(e_dl));
        chk({tag, ".phase"}, 32'(bus.LCT_PHASE), 32'(e_ph));
        chk({tag, ".nlct"},  32'(bus.NLCT),      32'(n));
        chk({tag, ".emptb"}, 32'(bus.EMPT_B),    32'(n != 0));
        chk({tag, ".full1"}, 32'(bus.FULL_1),    32'(n >= 15));
        chk({tag, ".full"},  32'(bus.FULL),      32'(n == 16));
    endtask

    // Drive one cycle of inputs, clock it, then compare 1 time unit later.
    task automatic step(input string tag, input logic push, input logic pop,
                        input logic lct, input logic en, input logic dis,
                        input logic [3:0] load, input logic [11:0] din,
                        input logic [2:0] sf);
        bus.PUSH      = push;
        bus.POP       = pop;
        bus.LCT       = lct;
        bus.ENBL50    = en;
        bus.DISBL50   = dis;
        bus.LOADPBLK  = load;
        bus.DIN       = din;
        bus.DSCAFULL  = sf;
        bus.PREBLKEND = 1'($urandom_range(0, 1));
        @(posedge clk);
        model_edge(push, pop, lct, en, dis, load, din, sf);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        bus.PUSH = 1'b0; bus.POP = 1'b0; bus.LCT = 1'b0;
        bus.ENBL50 = 1'b0; bus.DISBL50 = 1'b0; bus.PREBLKEND = 1'b0;
        bus.LOADPBLK = 4'h0; bus.DIN = 12'h000; bus.DSCAFULL = 3'b000;
    endtask

    logic [3:0]  head_before;
    logic [11:0] rdin;

    initial begin
        n_vec = 0;
        n_err = 0;
        idle_inputs();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.nlct0", 32'(bus.NLCT), 32'd0);
        rst = 1'b0;

        // Three-nibble drain starting at the pre block.
        step("a5c_push", 1, 0, 0, 0, 0, 4'h8, 12'hA5C, 3'b010);
        chk("a5c_pre", 32'(bus.DOUT), 32'hA);
        step("a5c_pop1", 0, 1, 0, 0, 0, 4'h8, 12'h000, 3'b000);
        chk("a5c_lct", 32'(bus.DOUT), 32'h5);
        chk("a5c_lct_sf", 32'(bus.DLSCAFULL), 32'd1);
        step("a5c_pop2", 0, 1, 0, 0, 0, 4'h8, 12'h000, 3'b000);
        chk("a5c_post", 32'(bus.DOUT), 32'hC);
        step("a5c_pop3", 0, 1, 0, 0, 0, 4'h8, 12'h000, 3'b000);
        chk("a5c_empty", 32'(bus.EMPT_B), 32'd0);

        // Two-nibble drain without the pre block.
        step("nopre_push", 1, 0, 0, 0, 0, 4'h0, 12'hA5C, 3'b010);
        chk("nopre_first", 32'(bus.DOUT), 32'h5);
        step("nopre_pop1", 0, 1, 0, 0, 0, 4'h0, 12'h000, 3'b000);
        chk("nopre_post", 32'(bus.DOUT), 32'hC);
        step("nopre_pop2", 0, 1, 0, 0, 0, 4'h0, 12'h000, 3'b000);
        chk("nopre_retired", 32'(bus.NLCT), 32'd0);

        // Phase capture.
        step("ph_en",    0, 0, 0, 1, 0, 4'h0, 12'h000, 3'b000);
        step("ph_lct1",  0, 0, 1, 0, 0, 4'h0, 12'h000, 3'b000);
        step("ph_push1", 1, 0, 0, 0, 0, 4'h0, 12'h123, 3'b000);
        chk("phase_one", 32'(bus.LCT_PHASE), 32'd1);
        step("ph_dis",   0, 0, 0, 0, 1, 4'h0, 12'h000, 3'b000);
        step("ph_lct0",  0, 0, 1, 0, 0, 4'h0, 12'h000, 3'b000);
        step("ph_push2", 1, 0, 0, 0, 0, 4'h0, 12'h456, 3'b000);
        step("ph_pop1",  0, 1, 0, 0, 0, 4'h0, 12'h000, 3'b000);
        step("ph_pop2",  0, 1, 0, 0, 0, 4'h0, 12'h000, 3'b000);
        chk("phase_zero", 32'(bus.LCT_PHASE), 32'd0);
        step("ph_pop3",  0, 1, 0, 0, 0, 4'h0, 12'h000, 3'b000);
        step("ph_pop4",  0, 1, 0, 0, 0, 4'h0, 12'h000, 3'b000);

        // Fill to 16, then a dropped 17th push.
        for (int i = 0; i < 16; i++) begin
            rdin = 12'($urandom);
            step("fill", 1, 0, 0, 0, 0, 4'h8, rdin, 3'($urandom));
            if (i == 14) chk("fill_full1_at15", 32'(bus.FULL_1), 32'd1);
        end
        chk("fill_full", 32'(bus.FULL), 32'd1);
        chk("fill_nlct16", 32'(bus.NLCT), 32'd16);
        head_before = bus.DOUT;
        step("push17", 1, 0, 0, 0, 0, 4'h8, 12'hFFF, 3'b111);
        chk("push17_nlct", 32'(bus.NLCT), 32'd16);
        chk("push17_head", 32'(bus.DOUT), 32'(head_before));

        // Push together with a retiring pop while full.
        for (int i = 0; i < 4 && m_pos != 2; i++)
            step("to_post", 0, 1, 0, 0, 0, 4'h8, 12'h000, 3'b000);
        step("full_pushpop", 1, 1, 0, 0, 0, 4'h8, 12'hBEE, 3'b101);
        chk("full_pushpop_nlct", 32'(bus.NLCT), 32'd16);

        // Drain everything, then pop on empty.
        for (int i = 0; i < 60 && mq.size() > 0; i++)
            step("drain", 0, 1, 0, 0, 0, 4'h8, 12'h000, 3'b000);
        chk("drained", 32'(bus.NLCT), 32'd0);
        step("pop_empty", 0, 1, 0, 0, 0, 4'h8, 12'h000, 3'b000);
        step("pushpop_empty", 1, 1, 0, 0, 0, 4'h8, 12'h777, 3'b001);
        chk("pushpop_empty_nlct", 32'(bus.NLCT), 32'd1);

        // Asynchronous reset mid-drain.
        step("pre_rst_push", 1, 0, 0, 0, 0, 4'h8, 12'h9AB, 3'b111);
        step("pre_rst_pop",  0, 1, 0, 0, 0, 4'h8, 12'h000, 3'b000);
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("arst");
        chk("arst_emptb", 32'(bus.EMPT_B), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("arst_hold");

        // Randomized traffic in fill-heavy, balanced and drain-heavy phases.
        for (int i = 0; i < 3000; i++) begin
            int mode;
            int pp;
            mode = (i / 250) % 3;
            pp   = (mode == 0) ? 80 : (mode == 1) ? 50 : 20;
            step("rand",
                 1'($urandom_range(0, 99) < pp),
                 1'($urandom_range(0, 99) < (100 - pp) + 10),
                 1'($urandom_range(0, 99) < 30),
                 1'($urandom_range(0, 99) < 10),
                 1'($urandom_range(0, 99) < 10),
                 4'($urandom_range(0, 15)),
                 12'($urandom),
                 3'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
